// File: rtl/gp_regfile_pkg.sv
// Shared definitions for the general-purpose register file slice.
// Holds the default operand width and register count used across the
// codebase, and the state encoding of the sequential-clear controller.
package gp_regfile_pkg;

    localparam int DEF_OPERAND_SIZE = 8;
    localparam int DEF_NUM_REGS     = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/gp_regfile_rdport.sv
// One registered read port of the register file.
// Ports:
//   clk, reset        - falling-edge clock, synchronous active-low reset
//   en, addr          - read request
//   clearing          - file is being cleared; the read is refused
//   wr_en/addr/data   - the write actually committed on this edge (bypass source)
//   reg_file, pend    - current register contents and pending bits
//   data, valid       - registered read result
module gp_regfile_rdport
    import gp_regfile_pkg::*;
#(
    parameter int OPERAND_SIZE = DEF_OPERAND_SIZE,
    parameter int NUM_REGS     = DEF_NUM_REGS,
    localparam int ADDR_W      = $clog2(NUM_REGS)
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   en,
    input  logic [ADDR_W-1:0]                      addr,
    input  logic                                   clearing,
    input  logic                                   wr_en,
    input  logic [ADDR_W-1:0]                      wr_addr,
    input  logic [OPERAND_SIZE-1:0]                wr_data,
    input  logic [NUM_REGS-1:0][OPERAND_SIZE-1:0]  reg_file,
    input  logic [NUM_REGS-1:0]                    pend,
    output logic [OPERAND_SIZE-1:0]                data,
    output logic                                   valid
);

    logic hit;
    logic usable;

    // A same-edge write both supplies the data and satisfies a pending register.
    assign hit    = wr_en && (wr_addr == addr);
    assign usable = en && !clearing && (hit || !pend[addr]);

    always_ff @(negedge clk) begin
        if (!reset) begin
            data  <= '0;
            valid <= 1'b0;
        end else begin
            valid <= usable;
            if (usable) begin
                data <= hit ? wr_data : reg_file[addr];
            end
        end
    end

endmodule

// File: rtl/gp_regfile_mp.sv
// Multi-port general-purpose register file: one write port, two registered
// read ports with write bypass, a per-register pending scoreboard and a
// sequential whole-file clear. All state changes on the falling clock edge.
// Ports:
//   clk, reset                  - falling-edge clock, synchronous active-low reset
//   wr_en, wr_addr, wr_data     - write request
//   rd0_*/rd1_*                 - read requests and registered results
//   rsv_en, rsv_addr            - mark a register pending
//   pend_vec                    - per-register pending bits
//   clear_req, clear_busy       - start / status of the sequential clear
module gp_regfile_mp
    import gp_regfile_pkg::*;
#(
    parameter int OPERAND_SIZE = DEF_OPERAND_SIZE,
    parameter int NUM_REGS     = DEF_NUM_REGS,
    localparam int ADDR_W      = $clog2(NUM_REGS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [OPERAND_SIZE-1:0] wr_data,
    input  logic                    rd0_en,
    input  logic [ADDR_W-1:0]       rd0_addr,
    input  logic                    rd1_en,
    input  logic [ADDR_W-1:0]       rd1_addr,
    output logic [OPERAND_SIZE-1:0] rd0_data,
    output logic [OPERAND_SIZE-1:0] rd1_data,
    output logic                    rd0_valid,
    output logic                    rd1_valid,
    input  logic                    rsv_en,
    input  logic [ADDR_W-1:0]       rsv_addr,
    output logic [NUM_REGS-1:0]     pend_vec,
    input  logic                    clear_req,
    output logic                    clear_busy
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_t                                 state;
    state_t                                 next_state;
    logic [ADDR_W-1:0]                      idx;
    logic [NUM_REGS-1:0][OPERAND_SIZE-1:0]  regs;
    logic [NUM_REGS-1:0]                    pend;
    logic                                   clearing;
    logic                                   wr_act;

    assign clearing   = (state == CLEAR);
    assign wr_act     = wr_en && !clearing;
    assign clear_busy = clearing;
    assign pend_vec   = pend;

    always_ff @(negedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (clear_req) next_state = CLEAR;
            CLEAR:   if (idx == LAST_IDX) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Reserve is applied after the write so it wins on a shared address.
    always_ff @(negedge clk) begin
        if (!reset) begin
            regs <= '0;
            pend <= '0;
            idx  <= '0;
        end else if (clearing) begin
            regs[idx] <= '0;
            pend[idx] <= 1'b0;
            idx       <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
        end else begin
            if (wr_en) begin
                regs[wr_addr] <= wr_data;
                pend[wr_addr] <= 1'b0;
            end
            if (rsv_en) begin
                pend[rsv_addr] <= 1'b1;
            end
        end
    end

    gp_regfile_rdport #(
        .OPERAND_SIZE(OPERAND_SIZE),
        .NUM_REGS    (NUM_REGS)
    ) u_rd0 (
        .clk      (clk),
        .reset    (reset),
        .en       (rd0_en),
        .addr     (rd0_addr),
        .clearing (clearing),
        .wr_en    (wr_act),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .reg_file (regs),
        .pend     (pend),
        .data     (rd0_data),
        .valid    (rd0_valid)
    );

    gp_regfile_rdport #(
        .OPERAND_SIZE(OPERAND_SIZE),
        .NUM_REGS    (NUM_REGS)
    ) u_rd1 (
        .clk      (clk),
        .reset    (reset),
        .en       (rd1_en),
        .addr     (rd1_addr),
        .clearing (clearing),
        .wr_en    (wr_act),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .reg_file (regs),
        .pend     (pend),
        .data     (rd1_data),
        .valid    (rd1_valid)
    );

endmodule
